// File: rtl/chacha_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chacha_ctr_pkg
// Description : Shared types and constants for the ChaCha modular counter:
//               burst FSM state encoding and count-direction constants.
// Revision    : 1.0 - initial release
// ============================================================================
package chacha_ctr_pkg;

    // Burst-control FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctr_state_e;

    // Values of the dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : chacha_ctr_pkg
`default_nettype wire

// File: rtl/mod_counter_step.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_step
// Description : Combinational next-value logic for a modulo-MOD counter.
//               Computes count +/- 1 with wrap at 0 / MOD-1 and flags the
//               wrapping step.
//               Optional feature macro: CHACHA_MOD_COUNTER_SATURATE_EN
//               (when defined the counter saturates at the range ends
//               instead of wrapping, and wrap_next is always 0).
// Ports       : count      in  WIDTH  current count value
//               dir        in  1      0 = up, 1 = down
//               next_value out WIDTH  value after one advance
//               wrap_next  out 1      advance crosses the modulus boundary
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter_step
    import chacha_ctr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_value,
    output logic             wrap_next
);

    localparam int unsigned      MAX_INT = MOD - 1;
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_INT[WIDTH-1:0];

    always_comb begin
        next_value = count;
        wrap_next  = 1'b0;
        if (dir == DIR_UP) begin
            if (count == MAX_VAL) begin
`ifdef CHACHA_MOD_COUNTER_SATURATE_EN
                next_value = MAX_VAL;
                wrap_next  = 1'b0;
`else
                next_value = '0;
                wrap_next  = 1'b1;
`endif
            end else begin
                next_value = count + 1'b1;
            end
        end else begin
            if (count == '0) begin
`ifdef CHACHA_MOD_COUNTER_SATURATE_EN
                next_value = '0;
                wrap_next  = 1'b0;
`else
                next_value = MAX_VAL;
                wrap_next  = 1'b1;
`endif
            end else begin
                next_value = count - 1'b1;
            end
        end
    end

endmodule : mod_counter_step
`default_nettype wire

// File: rtl/chacha_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : chacha_mod_counter
// Description : Loadable modulo-MOD up/down counter with count enable, wrap
//               pulse and a burst mode that advances a programmed number of
//               steps then pulses done. Used for the ChaCha20 round index and
//               word/quarter-round selectors.
//               Optional feature macro: CHACHA_MOD_COUNTER_SATURATE_EN
//               (saturate at range ends instead of wrapping; wrap stays 0).
// Parameters  : WIDTH (count width), MOD (2 <= MOD <= 2**WIDTH),
//               RESET_VAL (< MOD)
// Ports       : clk, reset      clock, synchronous active-high reset
//               load/load_value load count (clamped to MOD-1), aborts burst
//               en, dir         advance enable (stall in burst), direction
//               start, steps    launch a burst of `steps` advances
//               count, wrap     registered count, registered wrap pulse
//               at_zero         combinational count == 0
//               busy, done      registered burst status
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_mod_counter
    import chacha_ctr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             dir,
    input  logic             start,
    input  logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      MAX_INT   = MOD - 1;
    localparam logic [WIDTH-1:0] MAX_VAL   = MAX_INT[WIDTH-1:0];
    localparam int unsigned      RST_INT   = RESET_VAL;
    localparam logic [WIDTH-1:0] RST_COUNT = RST_INT[WIDTH-1:0];

    ctr_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_value;
    logic             step_wrap;
    logic [WIDTH-1:0] load_clamped;

    mod_counter_step #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_step (
        .count      (count_q),
        .dir        (dir),
        .next_value (step_value),
        .wrap_next  (step_wrap)
    );

    // Out-of-range loads land on the top of the legal range
    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        wrap_d  = 1'b0;

        if (load) begin
            // Load wins over everything but reset and abandons any burst
            count_d = load_clamped;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // The start cycle only arms the burst; no advance
                        if (steps != '0) begin
                            rem_d   = steps;
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (en) begin
                        count_d = step_value;
                        wrap_d  = step_wrap;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        count_d = step_value;
                        wrap_d  = step_wrap;
                        rem_d   = rem_q - 1'b1;
                        if (rem_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags are registered copies of the upcoming state
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= RST_COUNT;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign at_zero = (count_q == '0);

endmodule : chacha_mod_counter
`default_nettype wire
